// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its iterative mul/div unit:
// ALUop classes, R-type Funct codes, ALUSel codes, FSM states and engine ops.
package alu_ctrl_pkg;

   // ALUop classes from the main control unit
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_RTYPE = 3'b001;
   localparam logic [2:0] ALUOP_SUB   = 3'b010;
   localparam logic [2:0] ALUOP_ANDI  = 3'b011;
   localparam logic [2:0] ALUOP_ORI   = 3'b100;

   // R-type function fields
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   // ALU operation selects
   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_SUB = 4'b0110;
   localparam logic [3:0] SEL_SLT = 4'b0111;
   localparam logic [3:0] SEL_NOR = 4'b1100;

   // Mul/div sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   // Engine operation: bit 0 selects divide, bit 1 selects signed operands
   typedef enum logic [1:0] {
      MD_MULTU = 2'b00,
      MD_DIVU  = 2'b01,
      MD_MULT  = 2'b10,
      MD_DIV   = 2'b11
   } md_op_e;

endpackage

// File: rtl/alu_ctrl_seq_muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per
// cycle for WIDTH cycles, with a one-cycle shortcut for divide by zero.
// Signed operands are reduced to magnitudes on accept and the signs are
// reapplied combinationally while the result is presented in DONE.
module muldiv_iter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  md_op_e           op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {HI-side, LO-side} working register
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   a_raw_q, a_raw_d; // untouched rs, returned as HI on divide by zero
   logic               div_q, div_d;
   logic               div0_q, div0_d;
   logic               neg_q, neg_d;     // product / quotient must be negated
   logic               rneg_q, rneg_d;   // remainder takes the dividend's sign

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   logic [WIDTH:0]     div_trial, div_diff;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   // Operand magnitudes and single-step datapath for both engines
   always_comb begin
      a_neg     = op_i[1] & a_i[WIDTH-1];
      b_neg     = op_i[1] & b_i[WIDTH-1];
      a_mag     = a_neg ? -a_i : a_i;
      b_mag     = b_neg ? -b_i : b_i;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mul_step  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd_q};
      div_step  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end

   // Next-state and datapath update for the sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      a_raw_d = a_raw_q;
      div_d   = div_q;
      div0_d  = div0_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = op_i[0] ? ST_DIV : ST_MUL;
               cnt_d   = '0;
               a_raw_d = a_i;
               div_d   = op_i[0];
               div0_d  = op_i[0] & (b_i == '0);
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               if (op_i[0]) begin
                  acc_d  = {{WIDTH{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, b_mag};
                  opnd_d = a_mag;
               end
            end
         end
         ST_MUL: begin
            acc_d = mul_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
         end
         ST_DIV: begin
            if (div0_q) begin
               state_d = ST_DONE;
            end else begin
               acc_d = div_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state register; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Counter, accumulator and operand registers, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         a_raw_q <= '0;
         div_q   <= 1'b0;
         div0_q  <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         a_raw_q <= a_raw_d;
         div_q   <= div_d;
         div0_q  <= div0_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
      end
   end

   // Final result with sign correction; only sampled by the owner during DONE
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = acc_q[WIDTH-1:0];
      rem  = acc_q[2*WIDTH-1:WIDTH];
      if (!div_q) begin
         hi_o = prod[2*WIDTH-1:WIDTH];
         lo_o = prod[WIDTH-1:0];
      end else if (div0_q) begin
         hi_o = a_raw_q;
         lo_o = '1;
      end else begin
         hi_o = rneg_q ? -rem : rem;
         lo_o = neg_q  ? -quo : quo;
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with an attached iterative mul/div unit and HI/LO
// registers. Decodes ALUop/Funct into ALUSel, serves MFHI/MFLO, and stalls the
// pipeline when a dependent instruction meets a busy mul/div unit.
// Optional macro ALU_CTRL_SIGNED_MULDIV_EN adds signed MULT/DIV.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FUNCT_W = 6,
   parameter int OP_W    = 3,
   parameter int SEL_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid,
   input  logic [OP_W-1:0]    ALUop,
   input  logic [FUNCT_W-1:0] Funct,
   input  logic [WIDTH-1:0]   rs_val,
   input  logic [WIDTH-1:0]   rt_val,
   output logic [SEL_W-1:0]   ALUSel,
   output logic               hilo_sel,
   output logic [WIDTH-1:0]   hilo_out,
   output logic               busy,
   output logic               stall,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   logic             is_rtype;
   logic             f_mfhi, f_mflo;
   logic             md_hit, md_div, md_signed;
   logic             accept;
   md_op_e           md_op;
   logic             md_busy, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH-1:0] hi_q, lo_q;

   // ALU operation select, purely combinational
   always_comb begin
      ALUSel = SEL_W'(SEL_AND);
      case (ALUop)
         OP_W'(ALUOP_ADD):  ALUSel = SEL_W'(SEL_ADD);
         OP_W'(ALUOP_SUB):  ALUSel = SEL_W'(SEL_SUB);
         OP_W'(ALUOP_ANDI): ALUSel = SEL_W'(SEL_AND);
         OP_W'(ALUOP_ORI):  ALUSel = SEL_W'(SEL_OR);
         OP_W'(ALUOP_RTYPE): begin
            case (Funct)
               FUNCT_W'(F_ADD): ALUSel = SEL_W'(SEL_ADD);
               FUNCT_W'(F_SUB): ALUSel = SEL_W'(SEL_SUB);
               FUNCT_W'(F_AND): ALUSel = SEL_W'(SEL_AND);
               FUNCT_W'(F_OR):  ALUSel = SEL_W'(SEL_OR);
               FUNCT_W'(F_NOR): ALUSel = SEL_W'(SEL_NOR);
               FUNCT_W'(F_SLT): ALUSel = SEL_W'(SEL_SLT);
               default:         ALUSel = SEL_W'(SEL_AND);
            endcase
         end
         default: ALUSel = SEL_W'(SEL_AND);
      endcase
   end

   // Mul/div and HI/LO move classification of the current instruction
   always_comb begin
      is_rtype = (ALUop == OP_W'(ALUOP_RTYPE));
      f_mfhi   = is_rtype & (Funct == FUNCT_W'(F_MFHI));
      f_mflo   = is_rtype & (Funct == FUNCT_W'(F_MFLO));
      md_hit   = (Funct == FUNCT_W'(F_MULTU)) | (Funct == FUNCT_W'(F_DIVU));
      md_div   = (Funct == FUNCT_W'(F_DIVU));
      md_signed = 1'b0;
`ifdef ALU_CTRL_SIGNED_MULDIV_EN
      if ((Funct == FUNCT_W'(F_MULT)) || (Funct == FUNCT_W'(F_DIV))) begin
         md_hit    = 1'b1;
         md_signed = 1'b1;
         md_div    = (Funct == FUNCT_W'(F_DIV));
      end
`endif
      md_hit = md_hit & is_rtype;
      md_op  = md_op_e'({md_signed, md_div});
   end

   assign accept   = valid & md_hit & ~md_busy;
   assign busy     = md_busy;
   assign done     = md_done;
   assign stall    = md_busy & valid & (f_mfhi | f_mflo | md_hit);
   assign hilo_sel = f_mfhi | f_mflo;
   assign hilo_out = f_mfhi ? hi_q : (f_mflo ? lo_q : '0);
   assign hi       = hi_q;
   assign lo       = lo_q;

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept),
      .op_i    (md_op),
      .a_i     (rs_val),
      .b_i     (rt_val),
      .busy_o  (md_busy),
      .done_o  (md_done),
      .hi_o    (md_hi),
      .lo_o    (md_lo)
   );

   // HI/LO architectural registers, loaded as the engine leaves DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (md_done) begin
         hi_q <= md_hi;
         lo_q <= md_lo;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (WIDTH=32).
module tb_alu_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [2:0]  ALUop;
   logic [5:0]  Funct;
   logic [31:0] rs_val, rt_val;
   logic [3:0]  ALUSel;
   logic        hilo_sel;
   logic [31:0] hilo_out;
   logic        busy, stall, done;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   alu_ctrl_seq #(.WIDTH(32), .FUNCT_W(6), .OP_W(3), .SEL_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .ALUop(ALUop), .Funct(Funct),
      .rs_val(rs_val), .rt_val(rt_val), .ALUSel(ALUSel), .hilo_sel(hilo_sel),
      .hilo_out(hilo_out), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      valid  = 1'b1;
      ALUop  = op;
      Funct  = f;
      rs_val = a;
      rt_val = b;
   endtask

   task automatic bubble();
      valid = 1'b0;
      ALUop = 3'b000;
      Funct = 6'b000000;
   endtask

   // Counts busy/stall/done samples (one per cycle) until busy falls.
   task automatic count_busy(output int nb, output int ns, output int nd);
      bit ended;
      nb = 0; ns = 0; nd = 0; ended = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!busy) begin
            ended = 1;
            break;
         end
         nb++;
         if (stall) ns++;
         if (done) nd++;
         @(negedge clk);
      end
      if (!ended) check_eq("busy_timeout", 64'(ended), 64'd1);
   endtask

   logic [2:0] dec_op  [12] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                                3'b000, 3'b010, 3'b011, 3'b100, 3'b001, 3'b101};
   logic [5:0] dec_fn  [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
                                6'b100111, 6'b000000, 6'b000000, 6'b000000, 6'b111111, 6'b100000};
   logic [3:0] dec_exp [12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111,
                                4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 4'b0000};

   int nb, ns, nd;

   initial begin
      rst_n = 1'b0;
      bubble();
      rs_val = '0;
      rt_val = '0;

      // Reset state
      #3;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_hi", 64'(hi), 64'd0);
      check_eq("rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Decode sweep
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         issue(dec_op[i], dec_fn[i], 32'd0, 32'd0);
         #1;
         check_eq($sformatf("dec%0d_sel", i), 64'(ALUSel), 64'(dec_exp[i]));
         check_eq($sformatf("dec%0d_stall", i), 64'(stall), 64'd0);
      end
      check_eq("dec_hilo_sel", 64'(hilo_sel), 64'd0);
      check_eq("dec_hilo_out", 64'(hilo_out), 64'd0);

      // valid=0 still decodes, never accepts
      @(negedge clk);
      issue(3'b001, 6'b100010, 32'd1, 32'd1);
      valid = 1'b0;
      #1;
      check_eq("nv_sel", 64'(ALUSel), 64'h6);
      @(negedge clk);
      issue(3'b001, 6'b011001, 32'd3, 32'd3);
      valid = 1'b0;
      @(negedge clk);
      #1;
      check_eq("nv_busy", 64'(busy), 64'd0);

      // MULTU 0xFFFFFFFF * 2 with a dependent MFHI waiting behind it
      issue(3'b001, 6'b011001, 32'hFFFF_FFFF, 32'd2);
      @(negedge clk);
      issue(3'b001, 6'b010000, 32'd0, 32'd0);
      count_busy(nb, ns, nd);
      check_eq("mul_busy_cycles", 64'(nb), 64'd33);
      check_eq("mul_mfhi_stalls", 64'(ns), 64'd33);
      check_eq("mul_done_pulses", 64'(nd), 64'd1);
      check_eq("mul_hi", 64'(hi), 64'h1);
      check_eq("mul_lo", 64'(lo), 64'hFFFF_FFFE);
      check_eq("mfhi_stall_off", 64'(stall), 64'd0);
      check_eq("mfhi_sel", 64'(hilo_sel), 64'd1);
      check_eq("mfhi_out", 64'(hilo_out), 64'h1);

      // DIVU 100 / 7, then MFLO
      @(negedge clk);
      issue(3'b001, 6'b011011, 32'd100, 32'd7);
      @(negedge clk);
      bubble();
      count_busy(nb, ns, nd);
      check_eq("divu_busy_cycles", 64'(nb), 64'd33);
      check_eq("divu_done_pulses", 64'(nd), 64'd1);
      check_eq("divu_lo", 64'(lo), 64'd14);
      check_eq("divu_hi", 64'(hi), 64'd2);
      issue(3'b001, 6'b010010, 32'd0, 32'd0);
      #1;
      check_eq("mflo_sel", 64'(hilo_sel), 64'd1);
      check_eq("mflo_out", 64'(hilo_out), 64'd14);

      // DIVU by zero takes the shortcut
      @(negedge clk);
      issue(3'b001, 6'b011011, 32'd5, 32'd0);
      @(negedge clk);
      bubble();
      count_busy(nb, ns, nd);
      check_eq("div0_busy_cycles", 64'(nb), 64'd2);
      check_eq("div0_lo", 64'(lo), 64'hFFFF_FFFF);
      check_eq("div0_hi", 64'(hi), 64'd5);

      // Independent ADD during MULTU; second MULTU waits, then is accepted
      @(negedge clk);
      issue(3'b001, 6'b011001, 32'd3, 32'd5);
      @(negedge clk);
      issue(3'b001, 6'b100000, 32'd0, 32'd0);
      #1;
      check_eq("add_busy", 64'(busy), 64'd1);
      check_eq("add_stall", 64'(stall), 64'd0);
      check_eq("add_sel", 64'(ALUSel), 64'h2);
      @(negedge clk);
      issue(3'b001, 6'b011001, 32'd6, 32'd7);
      count_busy(nb, ns, nd);
      check_eq("b2b_stalls", 64'(ns), 64'd32);
      check_eq("b2b_stall_off", 64'(stall), 64'd0);
      check_eq("b2b_first_lo", 64'(lo), 64'd15);
      @(negedge clk);
      bubble();
      #1;
      check_eq("b2b_accepted", 64'(busy), 64'd1);
      count_busy(nb, ns, nd);
      check_eq("b2b_busy_cycles", 64'(nb), 64'd33);
      check_eq("b2b_lo", 64'(lo), 64'd42);
      check_eq("b2b_hi", 64'(hi), 64'd0);

`ifdef ALU_CTRL_SIGNED_MULDIV_EN
      // Signed DIV -7 / 2
      @(negedge clk);
      issue(3'b001, 6'b011010, 32'hFFFF_FFF9, 32'd2);
      @(negedge clk);
      bubble();
      count_busy(nb, ns, nd);
      check_eq("sdiv_busy_cycles", 64'(nb), 64'd33);
      check_eq("sdiv_lo", 64'(lo), 64'hFFFF_FFFD);
      check_eq("sdiv_hi", 64'(hi), 64'hFFFF_FFFF);
      // Signed MULT -3 * 4
      @(negedge clk);
      issue(3'b001, 6'b011000, 32'hFFFF_FFFD, 32'd4);
      @(negedge clk);
      bubble();
      count_busy(nb, ns, nd);
      check_eq("smul_hi", 64'(hi), 64'hFFFF_FFFF);
      check_eq("smul_lo", 64'(lo), 64'hFFFF_FFF4);
`else
      // DIV without signed support: no stall while busy, never accepted
      @(negedge clk);
      issue(3'b001, 6'b011001, 32'd1, 32'd1);
      @(negedge clk);
      issue(3'b001, 6'b011010, 32'd9, 32'd3);
      #1;
      check_eq("div_ns_busy", 64'(busy), 64'd1);
      check_eq("div_ns_stall", 64'(stall), 64'd0);
      check_eq("div_ns_sel", 64'(ALUSel), 64'h0);
      count_busy(nb, ns, nd);
      check_eq("div_ns_stalls", 64'(ns), 64'd0);
      @(negedge clk);
      #1;
      check_eq("div_ns_not_accepted", 64'(busy), 64'd0);
`endif

      // Asynchronous reset in the middle of a DIVU
      @(negedge clk);
      issue(3'b001, 6'b011011, 32'd100, 32'd7);
      @(negedge clk);
      bubble();
      repeat (9) @(negedge clk);
      #1;
      check_eq("pre_rst_busy", 64'(busy), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_done", 64'(done), 64'd0);
      check_eq("arst_hi", 64'(hi), 64'd0);
      check_eq("arst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(3'b001, 6'b011001, 32'd3, 32'd4);
      @(negedge clk);
      bubble();
      count_busy(nb, ns, nd);
      check_eq("post_rst_busy_cycles", 64'(nb), 64'd33);
      check_eq("post_rst_lo", 64'(lo), 64'd12);
      check_eq("post_rst_hi", 64'(hi), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
